// File: rtl/psk_modulator_if.sv
// ---------------------------------------------------------------------------
// psk_modulator_if : control inputs and IF sample outputs of psk_modulator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface psk_modulator_if #(
  parameter int OUT_W = 12
);
  logic                    ip_enable;
  logic                    ip_mode;
  logic [OUT_W-2:0]        ip_amp;
  logic signed [OUT_W-1:0] op_if;
  logic                    op_valid;
  logic                    op_sym_strobe;

  modport master (
    output ip_enable, ip_mode, ip_amp,
    input  op_if, op_valid, op_sym_strobe
  );

  modport slave (
    input  ip_enable, ip_mode, ip_amp,
    output op_if, op_valid, op_sym_strobe
  );
endinterface

`default_nettype wire

// File: rtl/psk_modulator.sv
// ---------------------------------------------------------------------------
// psk_modulator : PRBS-driven BPSK/QPSK modulator on an fs/4 carrier.
// Define PSK_MOD_DIFF_EN for per-rail differential encoding.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module psk_modulator #(
  parameter int OUT_W      = 12,
  parameter int SPS        = 8,
  parameter int PRBS_ORDER = 7
) (
  input  wire logic       ip_clock,
  input  wire logic       ip_reset,
  psk_modulator_if.slave  bus
);

  localparam int CW = $clog2(SPS);
  localparam int N  = PRBS_ORDER;

  logic [CW-1:0]           cnt;
  logic [1:0]              ph;
  logic [N-1:0]            lfsr;
  logic                    sym_i;
  logic                    sym_q;
  logic                    qpsk;
  logic signed [OUT_W-1:0] out_if;
  logic                    out_valid;
  logic                    out_strobe;

  logic                    load;
  logic                    bit1;
  logic                    bit2;
  logic [N-1:0]            step1;
  logic [N-1:0]            step2;
  logic                    enc_i;
  logic                    enc_q;
  logic                    cur_i;
  logic                    cur_q;
  logic                    cur_qpsk;
  logic signed [OUT_W-1:0] pos_a;
  logic signed [OUT_W-1:0] neg_a;
  logic signed [OUT_W-1:0] i_val;
  logic signed [OUT_W-1:0] q_val;
  logic signed [OUT_W-1:0] sample;

`ifdef PSK_MOD_DIFF_EN
  logic hist_i;
  logic hist_q;
`endif

  // Two LFSR steps are unrolled so QPSK can draw both rails in the load cycle.
  always_comb begin
    load  = bus.ip_enable && (cnt == '0);
    bit1  = lfsr[N-1] ^ lfsr[N-2];
    step1 = {lfsr[N-2:0], bit1};
    bit2  = step1[N-1] ^ step1[N-2];
    step2 = {step1[N-2:0], bit2};
`ifdef PSK_MOD_DIFF_EN
    enc_i = bit1 ^ hist_i;
    enc_q = bit2 ^ hist_q;
`else
    enc_i = bit1;
    enc_q = bit2;
`endif
    cur_i    = load ? enc_i : sym_i;
    cur_q    = load ? enc_q : sym_q;
    cur_qpsk = load ? bus.ip_mode : qpsk;
    pos_a    = $signed({1'b0, bus.ip_amp});
    neg_a    = -pos_a;
    i_val    = cur_i ? neg_a : pos_a;
    q_val    = cur_qpsk ? (cur_q ? neg_a : pos_a) : '0;
    case (ph)
      2'd0:    sample = i_val;
      2'd1:    sample = -q_val;
      2'd2:    sample = -i_val;
      default: sample = q_val;
    endcase
  end

  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      cnt        <= '0;
      ph         <= 2'd0;
      lfsr       <= '1;
      sym_i      <= 1'b0;
      sym_q      <= 1'b0;
      qpsk       <= 1'b0;
      out_if     <= '0;
      out_valid  <= 1'b0;
      out_strobe <= 1'b0;
`ifdef PSK_MOD_DIFF_EN
      hist_i     <= 1'b0;
      hist_q     <= 1'b0;
`endif
    end else if (bus.ip_enable) begin
      cnt        <= (cnt == CW'(SPS - 1)) ? '0 : cnt + CW'(1);
      ph         <= ph + 2'd1;
      out_if     <= sample;
      out_valid  <= 1'b1;
      out_strobe <= load;
      if (load) begin
        lfsr  <= bus.ip_mode ? step2 : step1;
        sym_i <= enc_i;
        sym_q <= enc_q;
        qpsk  <= bus.ip_mode;
`ifdef PSK_MOD_DIFF_EN
        hist_i <= enc_i;
        if (bus.ip_mode) hist_q <= enc_q;
`endif
      end
    end else begin
      out_if     <= '0;
      out_valid  <= 1'b0;
      out_strobe <= 1'b0;
    end
  end

  assign bus.op_if         = out_if;
  assign bus.op_valid      = out_valid;
  assign bus.op_sym_strobe = out_strobe;

endmodule

`default_nettype wire
